// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, S-box table, Rcon and RotWord helpers.
// Used by the key-expansion stages and by subbytes.
package aes_pkg;

  localparam int WORD = 32;
  localparam int NB   = 4;

  typedef logic [WORD-1:0] word_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Single-byte S-box lookup.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant word {rc, 24'h0} for rounds 1..10; other rounds give zero.
  function automatic word_t rcon(input int round);
    logic [7:0] rc;
    case (round)
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

  // {b0,b1,b2,b3} -> {b1,b2,b3,b0}, b0 being the most significant byte.
  function automatic word_t rotword(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word. Purely combinational
// so callers decide where the pipeline registers go.
module subword (
  input  logic [31:0] data,
  output logic [31:0] result
);
  import aes_pkg::*;

  // One S-box per byte, byte order preserved.
  assign result = {sbox(data[31:24]), sbox(data[23:16]), sbox(data[15:8]), sbox(data[7:0])};

endmodule

// File: rtl/key_expand_stage.sv
// One AES-128 key-expansion step on the skewed key bus: lane j of a key is
// presented one cycle after lane j-1, and the next round key leaves with the
// same skew four cycles later, ready for the next stage or a round's key input.
module key_expand_stage #(
  parameter int WORD  = 32,
  parameter int NB    = 4,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [WORD*NB-1:0]   i_key,
  output logic                 o_valid,
  output logic [WORD*NB-1:0]   o_key
);

  localparam logic [WORD-1:0] RCON = aes_pkg::rcon(ROUND);
  localparam int DEPTH = 3;

  logic [WORD-1:0] lane  [NB];
  logic [WORD-1:0] dly   [NB][DEPTH];
  logic [WORD-1:0] n_reg [NB];
  logic [WORD-1:0] rot;
  logic [WORD-1:0] sub;
  logic [3:0]      valid_sr;

  // Lane 0 occupies the most significant word of the bus.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    assign lane[l] = i_key[(NB-1-l)*WORD +: WORD];
  end

  // Lane 3 is used live: by the time it arrives the rest of the key is in the
  // delay lines, so the S-box sits directly in front of the n0 register.
  assign rot = aes_pkg::rotword(lane[NB-1]);

  subword u_subword (
    .data   (rot),
    .result (sub)
  );

  // Delay lines, XOR cascade and valid shift register; data moves every cycle
  // whether or not the slot is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the delay lines are a handful of flops rather than a RAM, so they
      // can be cleared alongside everything else and leave no stale words.
      for (int l = 0; l < NB; l++) begin
        for (int d = 0; d < DEPTH; d++) begin
          dly[l][d] <= '0;
        end
        n_reg[l] <= '0;
      end
      valid_sr <= '0;
    end else begin
      // NOTE: non-blocking updates let each stage read its neighbour's
      // pre-edge value, which is what makes this a shift chain.
      for (int l = 0; l < NB; l++) begin
        dly[l][0] <= lane[l];
        for (int d = 1; d < DEPTH; d++) begin
          dly[l][d] <= dly[l][d-1];
        end
      end
      n_reg[0] <= dly[0][DEPTH-1] ^ sub ^ RCON;
      for (int l = 1; l < NB; l++) begin
        n_reg[l] <= n_reg[l-1] ^ dly[l][DEPTH-1];
      end
      valid_sr <= {valid_sr[2:0], i_valid};
    end
  end

  // Output words are taken straight from the registers, so the skew is kept.
  for (genvar l = 0; l < NB; l++) begin : g_out
    assign o_key[(NB-1-l)*WORD +: WORD] = n_reg[l];
  end

  assign o_valid = valid_sr[3];

endmodule

// File: tb/tb_key_expand_stage.sv
// Directed bench for key_expand_stage: a ten-stage chain (ROUND 1..10) plus a
// standalone ROUND=10 stage share one skewed input bus. Stimulus and expected
// outputs are laid out per cycle up front, then the clock is run and every
// scheduled expectation is compared in the cycle it falls due.
module tb_key_expand_stage;

  localparam int NCYC = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         r10_valid;
  logic [127:0] r10_key;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 10; g++) begin : g_stage
    logic [127:0] in_key;
    logic [127:0] out_key;
    logic         in_valid;
    logic         out_valid;
    if (g == 0) begin : g_first
      assign in_key   = key_in;
      assign in_valid = key_valid;
    end else begin : g_next
      assign in_key   = g_stage[g-1].out_key;
      assign in_valid = g_stage[g-1].out_valid;
    end
    key_expand_stage #(.WORD(32), .NB(4), .ROUND(g + 1)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (in_valid),
      .i_key   (in_key),
      .o_valid (out_valid),
      .o_key   (out_key)
    );
  end

  key_expand_stage #(.WORD(32), .NB(4), .ROUND(10)) u_r10 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (key_valid),
    .i_key   (key_in),
    .o_valid (r10_valid),
    .o_key   (r10_key)
  );

  // Per-cycle stimulus and expectations. Source 0 = chain stage 1,
  // source 1 = chain stage 10, source 2 = standalone ROUND=10 stage.
  logic [31:0] lane_sched [NCYC][4];
  bit          valid_sched [NCYC];
  bit          rst_sched [NCYC];
  bit          exp_v [3][NCYC];
  bit          exp_len [3][NCYC][4];
  logic [31:0] exp_lane [3][NCYC][4];
  bit          exp_zero [NCYC];
  logic [7:0]  sbox_m [256];

  int cyc;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model: S-box from the GF(2^8) inverse and affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_m[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rc_model(input int round);
    logic [7:0] rc = 8'h01;
    for (int i = 1; i < round; i++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    return rc;
  endfunction

  function automatic logic [127:0] expand_m(input logic [127:0] k, input int round);
    logic [31:0] rot;
    logic [31:0] sub;
    logic [31:0] n0, n1, n2, n3;
    rot = {k[23:0], k[31:24]};
    sub = {sbox_m[rot[31:24]], sbox_m[rot[23:16]], sbox_m[rot[15:8]], sbox_m[rot[7:0]]};
    n0  = k[127:96] ^ sub ^ {rc_model(round), 24'h0};
    n1  = n0 ^ k[95:64];
    n2  = n1 ^ k[63:32];
    n3  = n2 ^ k[31:0];
    return {n0, n1, n2, n3};
  endfunction

  task automatic set_exp(input int s, input int c, input logic [127:0] e);
    exp_v[s][c] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_len[s][c+j][j]  = 1'b1;
      exp_lane[s][c+j][j] = e[127-32*j -: 32];
    end
  endtask

  // Place a key on the skewed bus with lane 0 at cycle t, plus its expected outputs.
  task automatic put_key(input int t, input logic [127:0] k, input logic [127:0] e1,
                         input logic [127:0] e10c, input logic [127:0] e10s, input bit expect_out);
    valid_sched[t] = 1'b1;
    for (int j = 0; j < 4; j++) lane_sched[t+j][j] = k[127-32*j -: 32];
    if (expect_out) begin
      set_exp(0, t + 4, e1);
      set_exp(1, t + 40, e10c);
      set_exp(2, t + 4, e10s);
    end
  endtask

  function automatic logic [127:0] chain_m(input logic [127:0] k);
    logic [127:0] e = k;
    for (int r = 1; r <= 10; r++) e = expand_m(e, r);
    return e;
  endfunction

  task automatic put_model(input int t, input logic [127:0] k, input bit expect_out);
    put_key(t, k, expand_m(k, 1), chain_m(k), expand_m(k, 10), expect_out);
  endtask

  function automatic logic [128:0] observe(input int s);
    case (s)
      0:       return {g_stage[0].out_valid, g_stage[0].out_key};
      1:       return {g_stage[9].out_valid, g_stage[9].out_key};
      default: return {r10_valid, r10_key};
    endcase
  endfunction

  task automatic apply(input int c);
    rst       = rst_sched[c];
    key_valid = valid_sched[c];
    key_in    = {lane_sched[c][0], lane_sched[c][1], lane_sched[c][2], lane_sched[c][3]};
  endtask

  task automatic do_checks(input int c);
    logic [128:0] ov;
    for (int s = 0; s < 3; s++) begin
      ov = observe(s);
      check($sformatf("src%0d valid @%0d", s, c), 128'(ov[128]), 128'(exp_v[s][c]));
      for (int j = 0; j < 4; j++) begin
        if (exp_len[s][c][j])
          check($sformatf("src%0d lane%0d @%0d", s, j, c), 128'(ov[127-32*j -: 32]), 128'(exp_lane[s][c][j]));
      end
      if (exp_zero[c])
        check($sformatf("src%0d key zero @%0d", s, c), ov[127:0], 128'h0);
    end
  endtask

  // Outputs settle right after the edge and have no combinational input path,
  // so inputs for the new cycle and output sampling share the same instant.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    apply(cyc);
    do_checks(cyc);
  endtask

  initial begin
    logic [127:0] k;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    build_sbox();

    for (int c = 0; c < NCYC; c++) begin
      for (int j = 0; j < 4; j++) begin
        lane_sched[c][j] = $urandom;
        exp_len[0][c][j] = 1'b0;
        exp_len[1][c][j] = 1'b0;
        exp_len[2][c][j] = 1'b0;
      end
      valid_sched[c] = 1'b0;
      rst_sched[c]   = 1'b0;
      exp_zero[c]    = 1'b0;
      for (int s = 0; s < 3; s++) exp_v[s][c] = 1'b0;
    end

    // Power-up reset for cycles 0..2; a valid pulse during reset must vanish.
    rst_sched[0] = 1'b1;
    rst_sched[1] = 1'b1;
    rst_sched[2] = 1'b1;
    valid_sched[1] = 1'b1;
    exp_zero[1] = 1'b1;
    exp_zero[3] = 1'b1;

    // FIPS-197 round 1 and the full ten-round chain from the cipher key.
    k = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    put_key(5, k, 128'ha0fafe17_88542cb1_23a33939_2a6c7605,
            128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, expand_m(k, 10), 1'b1);

    // Rcon 0x1B -> 0x36 boundary, back-to-back with the previous key.
    k = 128'hac7766f3_19fadc21_28d12941_575c006e;
    put_key(6, k, expand_m(k, 1), chain_m(k),
            128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1'b1);

    // Random keys streamed every cycle.
    for (int t = 7; t < 17; t++) put_model(t, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

    // Bubble: valid, garbage with valid low, valid.
    put_model(20, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
    put_model(22, 128'hffffffff_00000000_ffffffff_00000000, 1'b1);

    // Reset mid-flight: key at 70 is discarded by a reset pulse in cycle 72;
    // a fresh key enters in the first cycle after reset.
    put_model(70, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    rst_sched[72] = 1'b1;
    exp_zero[73]  = 1'b1;
    put_model(73, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);

    apply(0);
    while (cyc < NCYC - 4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
